// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match logic: bounce codes, match phases,
// winner codes and the rally-to-speed mapping.
package pong_pkg;

  localparam logic [1:0] BOUNCE_NONE   = 2'd0;
  localparam logic [1:0] BOUNCE_PADDLE = 2'd1;
  localparam logic [1:0] BOUNCE_WALL   = 2'd2;
  localparam logic [1:0] BOUNCE_SCORE  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE_WAIT,
    ST_PLAY,
    ST_POINT,
    ST_GAME_OVER
  } match_state_e;

  localparam logic [1:0] WINNER_NONE = 2'd0;
  localparam logic [1:0] WINNER_P1   = 2'd1;
  localparam logic [1:0] WINNER_P2   = 2'd2;

  // Speed step every 'hits' paddle contacts, capped at the top level.
  function automatic logic [1:0] speed_for_rally(input logic [5:0] rally,
                                                 input logic [5:0] hits);
    logic [5:0] level;
    level = rally / hits;
    return (level > 6'd3) ? 2'd3 : level[1:0];
  endfunction

endpackage

// File: rtl/frame_delay_timer.sv
// Counts frame ticks toward a target; done fires combinationally on the tick
// that reaches the target so the owner can leave its state on that same edge.
module frame_delay_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       tick,
  input  logic [7:0] target,
  output logic       done
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + 8'd1;
    end
  end

  assign done = tick && (({1'b0, count_q} + 9'd1) == {1'b0, target});

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pong_match_controller.sv
// Match-level sequencer: turns bounce event codes into game phases and owns
// scores, serve direction, rally speed and winner; held codes count once.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE          = 9,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POINT_PAUSE_FRAMES = 90,
  parameter int HITS_PER_LEVEL     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [1:0] bounce,
  input  logic       score_side,
  output logic       ball_enable,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic [1:0] speed_level,
  output logic [3:0] score_player_1,
  output logic [3:0] score_player_2,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [3:0] WIN     = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_T = 8'(SERVE_DELAY_FRAMES);
  localparam logic [7:0] PAUSE_T = 8'(POINT_PAUSE_FRAMES);
  localparam logic [5:0] HITS    = 6'(HITS_PER_LEVEL);

  match_state_e state_q;
  logic         start_q;
  logic         start_armed_q;
  logic [1:0]   bounce_q;
  logic [5:0]   rally_q;
  logic         ball_enable_q;
  logic         ball_hold_q;
  logic         serve_dir_q;
  logic [1:0]   speed_q;
  logic [3:0]   p1_q;
  logic [3:0]   p2_q;
  logic         over_q;
  logic [1:0]   winner_q;

  logic       start_rise;
  logic       paddle_rise;
  logic       score_hit;
  logic       timer_tick;
  logic       timer_clear;
  logic       timer_done;
  logic [7:0] timer_target;
  logic [5:0] rally_inc;

  // start must be seen low after reset before a rise counts, so a start held through reset is ignored.
  always_comb begin
    start_rise   = start && !start_q && start_armed_q;
    paddle_rise  = (bounce == BOUNCE_PADDLE) && (bounce_q != BOUNCE_PADDLE);
    score_hit    = (state_q == ST_PLAY) && (bounce == BOUNCE_SCORE);
    timer_tick   = frame_tick && ((state_q == ST_SERVE_WAIT) || (state_q == ST_POINT));
    timer_target = (state_q == ST_POINT) ? PAUSE_T : SERVE_T;
    timer_clear  = timer_done || score_hit ||
                   (start_rise && ((state_q == ST_IDLE) || (state_q == ST_GAME_OVER)));
    rally_inc    = (rally_q == 6'd63) ? rally_q : rally_q + 6'd1;
  end

  frame_delay_timer u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .tick   (timer_tick),
    .target (timer_target),
    .done   (timer_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      start_q       <= 1'b0;
      start_armed_q <= 1'b0;
      bounce_q      <= BOUNCE_NONE;
      rally_q       <= '0;
      ball_enable_q <= 1'b0;
      ball_hold_q   <= 1'b1;
      serve_dir_q   <= 1'b0;
      speed_q       <= '0;
      p1_q          <= '0;
      p2_q          <= '0;
      over_q        <= 1'b0;
      winner_q      <= WINNER_NONE;
    end else begin
      start_q       <= start;
      start_armed_q <= start_armed_q | ~start;
      bounce_q      <= bounce;
      case (state_q)
        ST_IDLE, ST_GAME_OVER: begin
          if (start_rise) begin
            p1_q          <= '0;
            p2_q          <= '0;
            winner_q      <= WINNER_NONE;
            over_q        <= 1'b0;
            rally_q       <= '0;
            speed_q       <= '0;
            serve_dir_q   <= 1'b1;
            ball_hold_q   <= 1'b1;
            ball_enable_q <= 1'b0;
            state_q       <= ST_SERVE_WAIT;
          end
        end
        ST_SERVE_WAIT: begin
          if (timer_done) begin
            ball_enable_q <= 1'b1;
            ball_hold_q   <= 1'b0;
            state_q       <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (score_hit) begin
            if (!score_side) begin
              if (p1_q < WIN) p1_q <= p1_q + 4'd1;
              serve_dir_q <= 1'b1;
            end else begin
              if (p2_q < WIN) p2_q <= p2_q + 4'd1;
              serve_dir_q <= 1'b0;
            end
            rally_q       <= '0;
            speed_q       <= '0;
            ball_enable_q <= 1'b0;
            ball_hold_q   <= 1'b0;
            state_q       <= ST_POINT;
          end else if (paddle_rise) begin
            rally_q <= rally_inc;
            speed_q <= speed_for_rally(rally_inc, HITS);
          end
        end
        ST_POINT: begin
          if (timer_done) begin
            ball_hold_q <= 1'b1;
            if ((p1_q == WIN) || (p2_q == WIN)) begin
              over_q   <= 1'b1;
              winner_q <= (p1_q == WIN) ? WINNER_P1 : WINNER_P2;
              state_q  <= ST_GAME_OVER;
            end else begin
              state_q  <= ST_SERVE_WAIT;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ball_enable    = ball_enable_q;
  assign ball_hold      = ball_hold_q;
  assign serve_dir      = serve_dir_q;
  assign speed_level    = speed_q;
  assign score_player_1 = p1_q;
  assign score_player_2 = p2_q;
  assign game_over      = over_q;
  assign winner         = winner_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller: a phase-level match model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_pong_match_controller;

  localparam int WIN   = 9;
  localparam int SERVE = 3;
  localparam int PAUSE = 45;
  localparam int HITS  = 4;

  localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_POINT = 3, P_OVER = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [1:0] bounce = 2'd0;
  logic       score_side = 1'b0;
  logic       ball_enable, ball_hold, serve_dir, game_over;
  logic [1:0] speed_level, winner;
  logic [3:0] score_player_1, score_player_2;

  int n_checks = 0;
  int n_fail   = 0;

  pong_match_controller #(
    .WIN_SCORE(WIN), .SERVE_DELAY_FRAMES(SERVE),
    .POINT_PAUSE_FRAMES(PAUSE), .HITS_PER_LEVEL(HITS)
  ) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
    .bounce(bounce), .score_side(score_side), .ball_enable(ball_enable),
    .ball_hold(ball_hold), .serve_dir(serve_dir), .speed_level(speed_level),
    .score_player_1(score_player_1), .score_player_2(score_player_2),
    .game_over(game_over), .winner(winner)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Match model in terms of phases, point tallies and rally hits.
  int m_phase, m_frames, m_rally, m_p1, m_p2, m_dir, m_winner;
  int m_last_start, m_prev_bounce;
  bit m_valid = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_phase = P_IDLE; m_frames = 0; m_rally = 0; m_p1 = 0; m_p2 = 0;
      m_dir = 0; m_winner = 0; m_last_start = 1; m_prev_bounce = 0;
      m_valid = 1'b1;
    end else begin
      case (m_phase)
        P_IDLE, P_OVER: if (start && m_last_start == 0) begin
          m_p1 = 0; m_p2 = 0; m_winner = 0; m_rally = 0; m_dir = 1;
          m_phase = P_SERVE; m_frames = 0;
        end
        P_SERVE: if (frame_tick) begin
          m_frames++;
          if (m_frames == SERVE) begin m_phase = P_PLAY; m_frames = 0; end
        end
        P_PLAY: begin
          if (bounce == 3) begin
            if (score_side == 0) begin m_p1 = (m_p1 < WIN) ? m_p1 + 1 : m_p1; m_dir = 1; end
            else begin m_p2 = (m_p2 < WIN) ? m_p2 + 1 : m_p2; m_dir = 0; end
            m_rally = 0; m_phase = P_POINT; m_frames = 0;
          end else if (bounce == 1 && m_prev_bounce != 1) begin
            m_rally = (m_rally < 63) ? m_rally + 1 : 63;
          end
        end
        P_POINT: if (frame_tick) begin
          m_frames++;
          if (m_frames == PAUSE) begin
            m_frames = 0;
            if (m_p1 == WIN) begin m_phase = P_OVER; m_winner = 1; end
            else if (m_p2 == WIN) begin m_phase = P_OVER; m_winner = 2; end
            else m_phase = P_SERVE;
          end
        end
        default: ;
      endcase
      m_last_start  = start;
      m_prev_bounce = bounce;
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("ball_enable", ball_enable, (m_phase == P_PLAY) ? 1 : 0);
      check("ball_hold", ball_hold,
            (m_phase == P_IDLE || m_phase == P_SERVE || m_phase == P_OVER) ? 1 : 0);
      check("serve_dir", serve_dir, m_dir);
      check("speed_level", speed_level, (m_rally / HITS > 3) ? 3 : m_rally / HITS);
      check("score_p1", score_player_1, m_p1);
      check("score_p2", score_player_2, m_p2);
      check("game_over", game_over, (m_phase == P_OVER) ? 1 : 0);
      check("winner", winner, m_winner);
    end
  end

  task automatic step(input bit t, input int b, input bit s, input bit st);
    frame_tick = t; bounce = 2'(b); score_side = s; start = st;
    @(posedge clock); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 0, 1'b0, 1'b0);
  endtask

  // One point for 'side', the full pause, then the serve delay.
  task automatic score_point(input bit side);
    step(1'b0, 3, side, 1'b0);
    ticks(PAUSE);
    ticks(SERVE);
  endtask

  initial begin
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    check("rst_hold", ball_hold, 1);
    check("rst_enable", ball_enable, 0);
    check("rst_dir", serve_dir, 0);
    check("rst_p1", score_player_1, 0);
    check("rst_winner", winner, 0);
    reset = 1'b0;
    step(1'b0, 0, 1'b0, 1'b0);

    // Start, then three spaced ticks to serve.
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    check("serve_hold_before_3rd", ball_hold, 1);
    step(1'b1, 0, 1'b0, 1'b0);
    check("play_enable", ball_enable, 1);
    check("play_dir", serve_dir, 1);

    // Held score code counts once.
    for (int i = 0; i < 20; i++) step(1'b0, 3, 1'b0, 1'b0);
    check("held_p1", score_player_1, 1);
    check("held_p2", score_player_2, 0);
    check("held_point_frozen", {ball_enable, ball_hold}, 0);
    check("held_dir", serve_dir, 1);
    ticks(PAUSE);
    check("pause_to_serve", ball_hold, 1);
    ticks(SERVE);

    // Paddle pulses, wall noise and one long held paddle code.
    for (int p = 1; p <= 9; p++) begin
      step(1'b0, 1, 1'b0, 1'b0);
      step(1'b0, 1, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      if (p == 7) check("speed_after_7", speed_level, 1);
      if (p == 8) check("speed_after_8", speed_level, 2);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    check("speed_held_once", speed_level, 2);

    // Score coincident with a tick: the tick is discarded.
    step(1'b1, 3, 1'b1, 1'b0);
    check("coinc_p2", score_player_2, 1);
    check("coinc_speed_clr", speed_level, 0);
    ticks(PAUSE - 1);
    check("coinc_still_point", ball_hold, 0);
    ticks(1);
    check("coinc_pause_done", ball_hold, 1);
    ticks(SERVE);

    for (int i = 0; i < 8; i++) score_point(1'b1);
    check("over_flag", game_over, 1);
    check("over_winner", winner, 2);
    check("over_p2", score_player_2, 9);
    check("over_p1", score_player_1, 1);
    for (int i = 0; i < 5; i++) step(1'b0, 3, 1'b1, 1'b0);
    check("frozen_p2", score_player_2, 9);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);
    check("restart_p2", score_player_2, 0);
    check("restart_over", game_over, 0);
    check("restart_hold", ball_hold, 1);
    ticks(SERVE);

    // Reset mid-pause at 3/2 with 40 ticks counted, start held through it.
    score_point(1'b0); score_point(1'b1); score_point(1'b0); score_point(1'b1);
    step(1'b0, 3, 1'b0, 1'b0);
    ticks(40);
    check("pre_rst_p1", score_player_1, 3);
    check("pre_rst_p2", score_player_2, 2);
    reset = 1'b1;
    step(1'b0, 0, 1'b0, 1'b1);
    reset = 1'b0;
    check("midrst_p1", score_player_1, 0);
    check("midrst_p2", score_player_2, 0);
    check("midrst_hold", ball_hold, 1);
    check("midrst_speed", speed_level, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 0, 1'b0, 1'b1);
    check("held_start_ignored", ball_enable, 0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    ticks(SERVE);
    check("rearmed_start", ball_enable, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
